// File: rtl/led_display_engine.sv
// LED pattern driver for the reaction-timer: per-state static patterns, blink, sweep chaser
// and a dev-mode status display. All animation timing restarts on every FSM state change.
module led_display_engine #(
   parameter int NUM_LEDS  = 16,
   parameter int BLINK_DIV = 25000000,
   parameter int SWEEP_DIV = 5000000,
   parameter int DIV_W     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          current_state,
   input  logic                dev_mode,
   input  logic                is_high_score,
   output logic [NUM_LEDS-1:0] LED
);

   localparam logic [2:0] STATE_IDLE        = 3'd0;
   localparam logic [2:0] STATE_PREP        = 3'd1;
   localparam logic [2:0] STATE_TEST        = 3'd2;
   localparam logic [2:0] STATE_RESULT_OK   = 3'd3;
   localparam logic [2:0] STATE_RESULT_FAIL = 3'd4;

   localparam int SW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(BLINK_DIV - 1);
   localparam logic [DIV_W-1:0] SWEEP_LAST = DIV_W'(SWEEP_DIV - 1);
   localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);
   localparam logic [SW-1:0]    POS_LAST   = SW'(NUM_LEDS - 1);
   localparam logic [SW-1:0]    POS_ONE    = SW'(1);
   localparam logic [SW:0]      HALF_W     = (SW+1)'(NUM_LEDS / 2);
   localparam logic [SW:0]      LEDS_W     = (SW+1)'(NUM_LEDS);

   logic [DIV_W-1:0] blink_cnt_r;
   logic [DIV_W-1:0] sweep_cnt_r;
   logic             blink_phase_r;
   logic [SW-1:0]    sweep_pos_r;
   logic [2:0]       prev_state_r;

   logic                state_chg_s;
   logic                blink_wrap_s;
   logic                sweep_wrap_s;
   logic                eff_phase_s;
   logic [SW-1:0]       eff_pos_s;
   logic [SW:0]         dot_sum_s;
   logic [SW-1:0]       hs_pos_s;
   logic [4:0]          top5_s;
   logic [NUM_LEDS-1:0] next_led_s;

   // Next LED pattern from pre-edge state; a state change shows phase 0 / pos 0 immediately
   always_comb begin
      state_chg_s  = (current_state != prev_state_r);
      blink_wrap_s = (blink_cnt_r == BLINK_LAST);
      sweep_wrap_s = (sweep_cnt_r == SWEEP_LAST);

      if (state_chg_s) begin
         eff_phase_s = 1'b0;
         eff_pos_s   = {SW{1'b0}};
      end else begin
         eff_phase_s = blink_phase_r;
         eff_pos_s   = sweep_pos_r;
      end

      // One extra bit so the opposite-dot wrap is correct for non-power-of-2 widths
      dot_sum_s = {1'b0, eff_pos_s} + HALF_W;
      if (dot_sum_s >= LEDS_W) begin
         dot_sum_s = dot_sum_s - LEDS_W;
      end else begin
         dot_sum_s = dot_sum_s;
      end
      hs_pos_s = dot_sum_s[SW-1:0];

      next_led_s = {NUM_LEDS{1'b0}};
      top5_s     = 5'b00000;

      if (dev_mode) begin
         case (current_state)
            STATE_IDLE:        top5_s = 5'b10000;
            STATE_PREP:        top5_s = 5'b01000;
            STATE_TEST:        top5_s = 5'b00100;
            STATE_RESULT_OK:   top5_s = 5'b00010;
            STATE_RESULT_FAIL: top5_s = 5'b00001;
            default:           top5_s = 5'b00000;
         endcase
         next_led_s[NUM_LEDS-1 -: 5] = top5_s;
         next_led_s[NUM_LEDS-6]      = is_high_score;
         next_led_s[NUM_LEDS-7]      = eff_phase_s;
         if (current_state == STATE_TEST) begin
            next_led_s[NUM_LEDS-8:0] = {(NUM_LEDS-7){1'b1}};
         end else begin
            next_led_s[NUM_LEDS-8:0] = {(NUM_LEDS-7){1'b0}};
         end
      end else begin
         case (current_state)
            STATE_IDLE:        next_led_s = {NUM_LEDS{1'b0}};
            STATE_PREP:        next_led_s = {NUM_LEDS{1'b0}};
            STATE_TEST:        next_led_s = {NUM_LEDS{1'b1}};
            STATE_RESULT_OK: begin
               next_led_s[eff_pos_s] = 1'b1;
               if (is_high_score) begin
                  next_led_s[hs_pos_s] = 1'b1;
               end else begin
                  next_led_s[hs_pos_s] = next_led_s[hs_pos_s];
               end
            end
            STATE_RESULT_FAIL: next_led_s = {NUM_LEDS{eff_phase_s}};
            default:           next_led_s = {NUM_LEDS{1'b0}};
         endcase
      end
   end

   // Prescalers, animation state, state tracking and the LED output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_r   <= {DIV_W{1'b0}};
         sweep_cnt_r   <= {DIV_W{1'b0}};
         blink_phase_r <= 1'b0;
         sweep_pos_r   <= {SW{1'b0}};
         prev_state_r  <= STATE_IDLE;
         LED           <= {NUM_LEDS{1'b0}};
      end else begin
         prev_state_r <= current_state;
         LED          <= next_led_s;
         if (state_chg_s) begin
            blink_cnt_r   <= {DIV_W{1'b0}};
            sweep_cnt_r   <= {DIV_W{1'b0}};
            blink_phase_r <= 1'b0;
            sweep_pos_r   <= {SW{1'b0}};
         end else begin
            if (blink_wrap_s) begin
               blink_cnt_r   <= {DIV_W{1'b0}};
               blink_phase_r <= ~blink_phase_r;
            end else begin
               blink_cnt_r   <= blink_cnt_r + CNT_ONE;
            end
            if (sweep_wrap_s) begin
               sweep_cnt_r <= {DIV_W{1'b0}};
               if (sweep_pos_r == POS_LAST) begin
                  sweep_pos_r <= {SW{1'b0}};
               end else begin
                  sweep_pos_r <= sweep_pos_r + POS_ONE;
               end
            end else begin
               sweep_cnt_r <= sweep_cnt_r + CNT_ONE;
            end
         end
      end
   end

endmodule
